// File: rtl/link_tx_arbiter.sv
// 8N1 UART transmitter shared between a one-entry link-port holding register
// and a small debug FIFO, granted round-robin at frame boundaries.
module link_tx_arbiter #(
    parameter int CLKS_PER_BIT = 36,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clockgb,
    input  logic                          reset,
    input  logic                          link_valid,
    input  logic [7:0]                    link_data,
    output logic                          link_ready,
    input  logic                          dbg_valid,
    input  logic [7:0]                    dbg_data,
    output logic                          dbg_ready,
    output logic [$clog2(FIFO_DEPTH):0]   dbg_count,
    output logic                          busy,
    output logic                          last_grant,
    output logic                          UART_TX
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_next;
    logic [BW-1:0] baud, baud_next;
    logic [2:0]    bit_idx, bit_idx_next, bit_idx_inc;
    logic [7:0]    shift, shift_next;
    logic          tx, tx_next;
    logic          last_grant_next;

    logic          link_pending;
    logic [7:0]    link_hold;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic baud_last, arb_window, dbg_pending;
    logic grant_link, grant_dbg, link_accept, dbg_push;

    assign link_ready  = !link_pending;
    assign dbg_ready   = (count != FIFO_FULL);
    assign dbg_count   = count;
    assign busy        = (state != IDLE) | link_pending | (count != '0);
    assign UART_TX     = tx;

    assign link_accept = link_valid & link_ready;
    assign dbg_push    = dbg_valid & dbg_ready;
    assign dbg_pending = (count != '0);
    assign baud_last   = (baud == BAUD_LAST);

    // Grants are only taken while idle or in the final stop-bit cycle, so the
    // next start bit follows the previous stop bit with no gap.
    assign arb_window  = (state == IDLE) | ((state == STOP) & baud_last);
    assign grant_link  = arb_window & link_pending & (!dbg_pending | last_grant);
    assign grant_dbg   = arb_window & dbg_pending & (!link_pending | !last_grant);

    always_comb begin
        state_next      = state;
        baud_next       = baud + BW'(1);
        bit_idx_next    = bit_idx;
        bit_idx_inc     = bit_idx + 3'd1;
        shift_next      = shift;
        tx_next         = tx;
        last_grant_next = last_grant;

        case (state)
            IDLE: begin
                baud_next = '0;
                tx_next   = 1'b1;
            end
            START: begin
                if (baud_last) begin
                    state_next   = DATA;
                    baud_next    = '0;
                    bit_idx_next = 3'd0;
                    tx_next      = shift[0];
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx_inc;
                        tx_next      = shift[bit_idx_inc];
                    end
                end
            end
            STOP: begin
                if (baud_last) begin
                    state_next = IDLE;
                    baud_next  = '0;
                    tx_next    = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                baud_next  = '0;
                tx_next    = 1'b1;
            end
        endcase

        if (grant_link | grant_dbg) begin
            state_next      = START;
            baud_next       = '0;
            bit_idx_next    = 3'd0;
            tx_next         = 1'b0;
            shift_next      = grant_link ? link_hold : fifo_mem[rd_ptr];
            last_grant_next = grant_dbg;
        end
    end

    always_ff @(posedge clockgb) begin
        if (reset) begin
            state      <= IDLE;
            baud       <= '0;
            bit_idx    <= 3'd0;
            shift      <= 8'h00;
            tx         <= 1'b1;
            last_grant <= 1'b1;
        end else begin
            state      <= state_next;
            baud       <= baud_next;
            bit_idx    <= bit_idx_next;
            shift      <= shift_next;
            tx         <= tx_next;
            last_grant <= last_grant_next;
        end
    end

    always_ff @(posedge clockgb) begin
        if (reset) begin
            link_pending <= 1'b0;
            link_hold    <= 8'h00;
        end else if (link_accept) begin
            link_pending <= 1'b1;
            link_hold    <= link_data;
        end else if (grant_link) begin
            link_pending <= 1'b0;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clockgb) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (dbg_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (grant_dbg) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({dbg_push, grant_dbg})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clockgb) begin
        if (!reset && dbg_push) begin
            fifo_mem[wr_ptr] <= dbg_data;
        end
    end

endmodule
